// File: rtl/thresh_auto_ctrl_if.sv
// Pixel snoop bus shared with the multi-level thresholder: gray value, valid and X/Y counters.
interface thresh_auto_ctrl_if;
    logic [7:0]        gray;
    logic              valid;
    logic signed [15:0] x_cont;
    logic signed [15:0] y_cont;

    modport master (output gray, valid, x_cont, y_cont);
    modport slave  (input  gray, valid, x_cont, y_cont);
endinterface

// File: rtl/thresh_auto_ctrl.sv
// Frame-synchronous threshold controller: tracks per-frame gray min/max and, at end of frame,
// loads auto (1/3, 2/3 of range) or manual thresholds into the thresholder.
module thresh_auto_ctrl #(
    parameter int H_ACT  = 800,
    parameter int V_ACT  = 480,
    parameter int DEF_T1 = 67,
    parameter int DEF_T2 = 111
) (
    input  logic               iClk,
    input  logic               iRst_n,
    thresh_auto_ctrl_if.slave  pix,
    input  logic               iAuto,
    input  logic [7:0]         iManThresh1,
    input  logic [7:0]         iManThresh2,
    input  logic               iSmoothReq,
    output logic [7:0]         oThresh1,
    output logic [7:0]         oThresh2,
    output logic               oSmooth,
    output logic               oUpdate,
    output logic [7:0]         oFrameMin,
    output logic [7:0]         oFrameMax,
    output logic               oBusy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] CALC  = 2'd2;
    localparam logic [1:0] APPLY = 2'd3;

    localparam logic signed [15:0] X_LAST = 16'(H_ACT - 1);
    localparam logic signed [15:0] Y_LAST = 16'(V_ACT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] min_q, min_d, max_q, max_d;
    logic [7:0] t1_q, t1_d, t2_q, t2_d, fmin_q, fmin_d, fmax_q, fmax_d;
    logic       smooth_q, smooth_d, upd_q, upd_d, busy_q, busy_d;

    logic        in_rng, acc, sof, eof;
    logic [7:0]  diff, a1, a2, m1, m2;
    logic [15:0] prod1, prod2;

    // Blanking pixels (negative or past-the-end counters) never reach the statistics.
    assign in_rng = !pix.x_cont[15] && (pix.x_cont <= X_LAST) &&
                    !pix.y_cont[15] && (pix.y_cont <= Y_LAST);
    assign acc = pix.valid && in_rng;
    assign sof = acc && (pix.x_cont == 16'sd0) && (pix.y_cont == 16'sd0);
    assign eof = acc && (pix.x_cont == X_LAST) && (pix.y_cont == Y_LAST);

    assign diff  = max_q - min_q;
    assign prod1 = {8'd0, diff} * 16'd85;
    assign prod2 = {8'd0, diff} * 16'd171;
    assign a1    = min_q + prod1[15:8];
    assign a2    = min_q + prod2[15:8];
    assign m1    = (iManThresh1 < iManThresh2) ? iManThresh1 : iManThresh2;
    assign m2    = (iManThresh1 < iManThresh2) ? iManThresh2 : iManThresh1;

    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        max_d    = max_q;
        t1_d     = t1_q;
        t2_d     = t2_q;
        smooth_d = smooth_q;
        fmin_d   = fmin_q;
        fmax_d   = fmax_q;
        busy_d   = busy_q;
        upd_d    = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                // SOF reloads from scratch in either state, which also covers truncated frames.
                if (sof) begin
                    min_d   = pix.gray;
                    max_d   = pix.gray;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end else if (acc && state_q == ACCUM) begin
                    min_d = (pix.gray < min_q) ? pix.gray : min_q;
                    max_d = (pix.gray > max_q) ? pix.gray : max_q;
                end
                if (eof && (sof || state_q == ACCUM)) begin
                    busy_d  = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Outputs are registered here so they are valid while APPLY holds oUpdate high.
                t1_d     = iAuto ? a1 : m1;
                t2_d     = iAuto ? a2 : m2;
                smooth_d = iSmoothReq;
                fmin_d   = min_q;
                fmax_d   = max_q;
                upd_d    = 1'b1;
                state_d  = APPLY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= IDLE;
            min_q    <= 8'd0;
            max_q    <= 8'd0;
            t1_q     <= 8'(DEF_T1);
            t2_q     <= 8'(DEF_T2);
            smooth_q <= 1'b0;
            fmin_q   <= 8'd0;
            fmax_q   <= 8'd255;
            upd_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            max_q    <= max_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            smooth_q <= smooth_d;
            fmin_q   <= fmin_d;
            fmax_q   <= fmax_d;
            upd_q    <= upd_d;
            busy_q   <= busy_d;
        end
    end

    assign oThresh1  = t1_q;
    assign oThresh2  = t2_q;
    assign oSmooth   = smooth_q;
    assign oUpdate   = upd_q;
    assign oFrameMin = fmin_q;
    assign oFrameMax = fmax_q;
    assign oBusy     = busy_q;
endmodule

// File: tb/tb_thresh_auto_ctrl.sv
// Scoreboard bench for thresh_auto_ctrl on a reduced frame size.
module tb_thresh_auto_ctrl;
    localparam int H = 16;
    localparam int V = 8;
    localparam int N = H * V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic auto_en = 1'b1;
    logic [7:0] man1 = 8'd0, man2 = 8'd0;
    logic smooth_req = 1'b0;
    logic [7:0] t1, t2, fmin, fmax;
    logic sm, upd, busy;

    thresh_auto_ctrl_if pix ();

    thresh_auto_ctrl #(.H_ACT(H), .V_ACT(V), .DEF_T1(67), .DEF_T2(111)) dut (
        .iClk(clk), .iRst_n(rst_n), .pix(pix.slave),
        .iAuto(auto_en), .iManThresh1(man1), .iManThresh2(man2), .iSmoothReq(smooth_req),
        .oThresh1(t1), .oThresh2(t2), .oSmooth(sm), .oUpdate(upd),
        .oFrameMin(fmin), .oFrameMax(fmax), .oBusy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t1, t2, sm, mn, mx, cyc;
    } exp_t;

    exp_t q[$];
    int nvec = 0, nerr = 0, cyc = 0;
    int cur_t1 = 67, cur_t2 = 111, cur_sm = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (upd) begin
            if (q.size() == 0) chk("spurious_upd", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("upd_cyc", cyc, e.cyc);
                chk("thresh1", t1, e.t1);
                chk("thresh2", t2, e.t2);
                chk("smooth", sm, e.sm);
                chk("fmin", fmin, e.mn);
                chk("fmax", fmax, e.mx);
                cur_t1 = e.t1; cur_t2 = e.t2; cur_sm = e.sm;
            end
        end
    end

    function automatic exp_t model(int lo, int hi);
        exp_t e;
        int d;
        d = hi - lo;
        if (auto_en) begin
            e.t1 = lo + ((d * 85) >> 8);
            e.t2 = lo + ((d * 171) >> 8);
        end else begin
            e.t1 = (man1 < man2) ? man1 : man2;
            e.t2 = (man1 < man2) ? man2 : man1;
        end
        e.sm = smooth_req; e.mn = lo; e.mx = hi; e.cyc = 0;
        return e;
    endfunction

    task automatic px(input int x, input int y, input int g, input bit v);
        pix.gray = 8'(g); pix.x_cont = 16'(x); pix.y_cont = 16'(y); pix.valid = v;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, 0, 1'b0);
    endtask

    // Ramp lo..hi over the frame; optional valid gaps, abort row, mid-frame reset row, mid-frame manual set.
    task automatic frame(input int lo, input int hi, input bit gaps, input int abort_y,
                         input int rst_y, input bit mid_set);
        bit killed = 1'b0;
        for (int y = 0; y < V; y++) begin
            if (y == abort_y) return;
            if (y == rst_y) begin
                rst_n = 1'b0; px(0, y, 0, 1'b0); rst_n = 1'b1;
                cur_t1 = 67; cur_t2 = 111; cur_sm = 0; killed = 1'b1;
                chk("rst_t1", t1, 67); chk("rst_t2", t2, 111); chk("rst_sm", sm, 0);
                chk("rst_busy", busy, 0); chk("rst_upd", upd, 0);
            end
            if (mid_set && y == V / 2) begin
                auto_en = 1'b0; man1 = 8'd150; man2 = 8'd40; smooth_req = 1'b1;
                px(-1, y, 7, 1'b1);
                chk("mid_t1_hold", t1, cur_t1); chk("mid_t2_hold", t2, cur_t2);
                chk("mid_sm_hold", sm, cur_sm);
            end
            px(-1, y, 0, 1'b1);
            for (int x = 0; x < H; x++) begin
                int g;
                g = lo + ((y * H + x) * (hi - lo)) / (N - 1);
                if (gaps && ($urandom_range(3) == 0)) px(x, y, 255, 1'b0);
                if (x == H - 1 && y == V - 1 && !killed) begin
                    exp_t e;
                    e = model(lo, hi);
                    e.cyc = cyc + 2;
                    q.push_back(e);
                end
                px(x, y, g, 1'b1);
                if (x == 0 && y == 1 && !killed) chk("busy_mid", busy, 1);
            end
            px(H, y, 255, 1'b1);
            px(-2, y, 0, 1'b1);
        end
        if (!killed) chk("busy_after_eof", busy, 0);
    endtask

    initial begin
        pix.gray = 8'd0; pix.valid = 1'b0; pix.x_cont = 16'sd0; pix.y_cont = 16'sd0;
        rst_n = 1'b0; idle(2); rst_n = 1'b1;
        idle(20);
        chk("idle_t1", t1, 67); chk("idle_t2", t2, 111); chk("idle_sm", sm, 0);
        chk("idle_fmin", fmin, 0); chk("idle_fmax", fmax, 255); chk("idle_busy", busy, 0);

        frame(20, 200, 1'b0, -1, -1, 1'b0); idle(4);
        chk("ramp_t1_const", t1, 79); chk("ramp_t2_const", t2, 140);

        frame(90, 90, 1'b0, -1, -1, 1'b0); idle(4);
        chk("flat_eq", t1, t2);

        frame(20, 200, 1'b0, -1, -1, 1'b1); idle(4);
        chk("man_t1", t1, 40); chk("man_t2", t2, 150); chk("man_sm", sm, 1);

        auto_en = 1'b1; smooth_req = 1'b0;
        frame(0, 255, 1'b0, 4, -1, 1'b0);
        frame(50, 60, 1'b0, -1, -1, 1'b0); idle(4);

        frame(20, 200, 1'b1, -1, -1, 1'b0); idle(4);
        frame(33, 177, 1'b1, -1, -1, 1'b0); idle(4);

        frame(20, 200, 1'b0, -1, -1, 1'b0); idle(4);
        frame(20, 200, 1'b0, -1, 3, 1'b0); idle(6);
        chk("post_rst_t1", t1, 67); chk("post_rst_t2", t2, 111); chk("post_rst_busy", busy, 0);

        frame(10, 100, 1'b0, -1, -1, 1'b0); idle(6);
        chk("pending_updates", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
